fir_mac_ctrl: RTL and testbench

- Sequencing FSM for the FIR multiply-accumulate datapath.
- On each new input sample it performs the following steps:
  - writes the sample into a circular sample buffer;
  - clears the accumulator;
  - issues one sample/coefficient address pair per cycle for every tap;
  - aligns the accumulator enable to the multiply/add pipeline latency;
  - commits the result to the output register.
- Sits between the sample-arrival logic and the acc_module, and drives the sample and coefficient memories.

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_valid_pipe.sv | 28 ++
 rtl/fir_mac_ctrl.sv | 157 +++++++++++++++
 tb/tb_fir_mac_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR multiply-accumulate control path.
package fir_pkg;

    localparam int ACC_W  = 21;
    localparam int ADDR_W = 5;
    localparam int N_TAPS = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        STORE,
        DONE
    } fsm_state_t;

endpackage

// File: rtl/fir_valid_pipe.sv
// Valid-bit delay line that lines up the accumulator enable with the
// multiply/add latency between address issue and suma_wynik.
module fir_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_in,
    output logic shift_out
);

    logic [DEPTH-1:0] stages;

    // Shift one bit per cycle; a reset flushes every in-flight enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= shift_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign shift_out = stages[DEPTH-1];

endmodule

// File: rtl/fir_mac_ctrl.sv
// Sequencer for the FIR MAC datapath: stores each new sample in the circular
// sample buffer, clears the accumulator, walks the taps, waits for the
// multiply/add pipeline to drain and commits the result.
module fir_mac_ctrl #(
    parameter int N_TAPS   = fir_pkg::N_TAPS,
    parameter int ADDR_W   = fir_pkg::ADDR_W,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk_b,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   taps_cfg,
    output logic              FSM_probka_we,
    output logic [ADDR_W-1:0] FSM_adres_probki,
    output logic [ADDR_W-1:0] FSM_adres_wsp,
    output logic              FSM_reset_Acc,
    output logic              FSM_Acc_en,
    output logic              FSM_Acc_zapis,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    import fir_pkg::*;

    localparam logic [ADDR_W:0] TAPS_MAX   = (ADDR_W+1)'(N_TAPS);
    localparam logic [2:0]      DRAIN_LAST = 3'(PIPE_LAT - 1);

    fsm_state_t        state, state_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   t_reg, t_nx;
    logic [ADDR_W:0]   k, k_nx;
    logic [2:0]        drain_cnt, drain_nx;
    logic [ADDR_W:0]   taps_clamped;
    logic              mac_active;

    logic              probka_we_nx;
    logic [ADDR_W-1:0] adres_probki_nx;
    logic [ADDR_W-1:0] adres_wsp_nx;
    logic              reset_acc_nx;
    logic              acc_zapis_nx;
    logic              busy_nx;
    logic              done_nx;

    assign taps_clamped = (taps_cfg > TAPS_MAX) ? TAPS_MAX : taps_cfg;
    assign mac_active   = (state == MAC);

    // A start outside IDLE is flagged in its own cycle, so it is decoded from
    // the state register rather than delayed by another flop.
    assign overrun = start && (state != IDLE);

    // Next-state, counters, and the values every output takes in the next state.
    always_comb begin
        state_nx        = state;
        t_nx            = t_reg;
        k_nx            = k;
        drain_nx        = drain_cnt;
        adres_probki_nx = FSM_adres_probki;
        adres_wsp_nx    = FSM_adres_wsp;

        case (state)
            IDLE: begin
                if (start) begin
                    t_nx     = taps_clamped;
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                k_nx     = '0;
                drain_nx = '0;
                state_nx = (t_reg == '0) ? DRAIN : MAC;
            end
            MAC: begin
                if (k == t_reg - 1'b1) begin
                    drain_nx = '0;
                    state_nx = DRAIN;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nx = STORE;
                end else begin
                    drain_nx = drain_cnt + 1'b1;
                end
            end
            STORE: begin
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        probka_we_nx = (state_nx == CLEAR);
        reset_acc_nx = (state_nx == CLEAR);
        acc_zapis_nx = (state_nx == STORE);
        done_nx      = (state_nx == DONE);
        busy_nx      = (state_nx != IDLE);

        if (state_nx == CLEAR) begin
            adres_probki_nx = wr_ptr;
            adres_wsp_nx    = '0;
        end else if (state_nx == MAC) begin
            adres_probki_nx = wr_ptr - k_nx[ADDR_W-1:0];
            adres_wsp_nx    = k_nx[ADDR_W-1:0];
        end
    end

    // State, counters and registered outputs; the write pointer moves on
    // once the frame is complete so the next sample lands in the next slot.
    always_ff @(posedge clk_b) begin
        if (rst) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            t_reg            <= '0;
            k                <= '0;
            drain_cnt        <= '0;
            FSM_probka_we    <= 1'b0;
            FSM_adres_probki <= '0;
            FSM_adres_wsp    <= '0;
            FSM_reset_Acc    <= 1'b0;
            FSM_Acc_zapis    <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_nx;
            t_reg            <= t_nx;
            k                <= k_nx;
            drain_cnt        <= drain_nx;
            FSM_probka_we    <= probka_we_nx;
            FSM_adres_probki <= adres_probki_nx;
            FSM_adres_wsp    <= adres_wsp_nx;
            FSM_reset_Acc    <= reset_acc_nx;
            FSM_Acc_zapis    <= acc_zapis_nx;
            busy             <= busy_nx;
            done             <= done_nx;
            if (state == DONE) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    fir_valid_pipe #(
        .DEPTH(PIPE_LAT)
    ) u_valid_pipe (
        .clk      (clk_b),
        .rst      (rst),
        .shift_in (mac_active),
        .shift_out(FSM_Acc_en)
    );

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Bench for fir_mac_ctrl: attaches a behavioural sample/coefficient memory,
// product pipeline and accumulator, predicts every frame from FIR arithmetic
// and scores the DUT's clear, tap, commit, done and overrun events.
module tb_fir_mac_ctrl;

    localparam int PIPE_LAT = 2;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    logic       clk_b;
    logic       rst;
    logic       start;
    logic [5:0] taps_cfg;
    logic       FSM_probka_we;
    logic [4:0] FSM_adres_probki;
    logic [4:0] FSM_adres_wsp;
    logic       FSM_reset_Acc;
    logic       FSM_Acc_en;
    logic       FSM_Acc_zapis;
    logic       busy;
    logic       done;
    logic       overrun;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  busy_until;
    int  ptr_model;
    int  direct_base;
    bit  direct_mode;
    int  sample_bus;
    int  sample_mem [32];
    int  coef_mem [32];
    int  mem_model [32];
    int  dly [PIPE_LAT];
    int  prod;
    int  suma_wynik;
    int  acc;
    int  result_reg;
    int  hist_wsp [8];
    int  hist_pr [8];

    ev_t q_clear [$];
    ev_t q_tap [$];
    ev_t q_done [$];
    ev_t q_ovr [$];

    fir_mac_ctrl #(
        .N_TAPS  (32),
        .ADDR_W  (5),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk_b           (clk_b),
        .rst             (rst),
        .start           (start),
        .taps_cfg        (taps_cfg),
        .FSM_probka_we   (FSM_probka_we),
        .FSM_adres_probki(FSM_adres_probki),
        .FSM_adres_wsp   (FSM_adres_wsp),
        .FSM_reset_Acc   (FSM_reset_Acc),
        .FSM_Acc_en      (FSM_Acc_en),
        .FSM_Acc_zapis   (FSM_Acc_zapis),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun)
    );

    initial clk_b = 1'b0;
    always #5 clk_b = ~clk_b;

    // Cycle index: the value of cyc names the clock cycle currently in progress.
    always @(posedge clk_b) cyc <= cyc + 1;

    // Attached datapath: sample buffer, coefficient ROM, product pipeline.
    always @(posedge clk_b) begin
        if (FSM_probka_we) sample_mem[FSM_adres_probki] <= sample_bus;
    end

    assign prod = sample_mem[FSM_adres_probki] * coef_mem[FSM_adres_wsp];

    always @(posedge clk_b) begin
        dly[0] <= prod;
        for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
    end

    assign suma_wynik = direct_mode
        ? (((cyc - direct_base) >= 4 && (cyc - direct_base) <= 7) ? (cyc - direct_base + 1) : 1000)
        : dly[PIPE_LAT-1];

    // Attached accumulator and output register.
    always @(posedge clk_b) begin
        if (FSM_reset_Acc) acc <= 0;
        else if (FSM_Acc_en) acc <= acc + suma_wynik;
        if (FSM_Acc_zapis) result_reg <= acc;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_b);
        #1;
    endtask

    task automatic applyReset();
        rst   = 1'b1;
        start = 1'b0;
        step();
        rst        = 1'b0;
        busy_until = cyc - 1;
        ptr_model  = 0;
    endtask

    // Drive one start pulse this cycle and record what the FIR should do with it.
    task automatic applyStimulus(input logic [5:0] taps, input logic [7:0] smp);
        int  s, t, p, res;
        ev_t ev;
        s        = cyc;
        start    = 1'b1;
        taps_cfg = taps;
        if (s > busy_until) begin
            t = (taps > 6'd32) ? 32 : int'(taps);
            p = ptr_model;
            sample_bus   = int'(smp);
            mem_model[p] = int'(smp);
            ev.cyc = s + 1; ev.a = p; ev.b = 0;
            q_clear.push_back(ev);
            res = 0;
            for (int k = 0; k < t; k++) begin
                ev.cyc = s + 2 + k + PIPE_LAT;
                ev.a   = k;
                ev.b   = (p - k) & 31;
                q_tap.push_back(ev);
                res += direct_mode ? (5 + k) : coef_mem[k] * mem_model[(p - k) & 31];
            end
            ev.cyc = s + t + PIPE_LAT + 3; ev.a = res; ev.b = 0;
            q_done.push_back(ev);
            busy_until  = ev.cyc;
            ptr_model   = (p + 1) & 31;
            direct_base = s;
        end else begin
            ev.cyc = s; ev.a = 0; ev.b = 0;
            q_ovr.push_back(ev);
        end
        step();
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        checkOutput("idle_wait", int'(busy), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk_b) begin
        ev_t ev;
        hist_wsp[cyc & 7] = int'(FSM_adres_wsp);
        hist_pr[cyc & 7]  = int'(FSM_adres_probki);
        if (rst) begin
            q_clear.delete();
            q_tap.delete();
            q_done.delete();
            q_ovr.delete();
        end else begin
            if (FSM_reset_Acc || FSM_Acc_en)
                checkOutput("clear_en_overlap", int'(FSM_reset_Acc && FSM_Acc_en), 0);
            if (FSM_reset_Acc) begin
                checkOutput("clear_expected", int'(q_clear.size() > 0), 1);
                if (q_clear.size() > 0) begin
                    ev = q_clear.pop_front();
                    checkOutput("clear_cycle", cyc, ev.cyc);
                    checkOutput("clear_we", int'(FSM_probka_we), 1);
                    checkOutput("clear_addr", int'(FSM_adres_probki), ev.a);
                end
            end
            if (FSM_Acc_en) begin
                checkOutput("tap_expected", int'(q_tap.size() > 0), 1);
                if (q_tap.size() > 0) begin
                    ev = q_tap.pop_front();
                    checkOutput("tap_cycle", cyc, ev.cyc);
                    checkOutput("tap_wsp", hist_wsp[(cyc - PIPE_LAT) & 7], ev.a);
                    checkOutput("tap_probki", hist_pr[(cyc - PIPE_LAT) & 7], ev.b);
                end
            end
            if (FSM_Acc_zapis) begin
                checkOutput("zapis_expected", int'(q_done.size() > 0), 1);
                if (q_done.size() > 0) checkOutput("zapis_cycle", cyc, q_done[0].cyc - 1);
            end
            if (done) begin
                checkOutput("done_expected", int'(q_done.size() > 0), 1);
                if (q_done.size() > 0) begin
                    ev = q_done.pop_front();
                    checkOutput("done_cycle", cyc, ev.cyc);
                    checkOutput("result", result_reg, ev.a);
                end
            end
            if (overrun) begin
                checkOutput("overrun_expected", int'(q_ovr.size() > 0), 1);
                if (q_ovr.size() > 0) begin
                    ev = q_ovr.pop_front();
                    checkOutput("overrun_cycle", cyc, ev.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sel, n;
        logic [5:0] t;
        rst         = 1'b1;
        start       = 1'b0;
        taps_cfg    = '0;
        sample_bus  = 0;
        direct_mode = 1'b0;
        busy_until  = 0;
        ptr_model   = 0;
        direct_base = 0;
        for (int i = 0; i < 32; i++) coef_mem[i] = int'($urandom_range(0, 255));
        step();
        applyReset();

        // Reset state
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_acc_en", int'(FSM_Acc_en), 0);
        checkOutput("rst_reset_acc", int'(FSM_reset_Acc), 0);
        checkOutput("rst_adres_probki", int'(FSM_adres_probki), 0);

        // Four taps with known accumulator inputs 5,6,7,8 -> 26
        $display("[TB] frame timing with 4 taps");
        direct_mode = 1'b1;
        applyStimulus(6'd4, 8'd17);
        for (int rel = 1; rel <= 10; rel++) begin
            checkOutput("t1_reset_acc", int'(FSM_reset_Acc), int'(rel == 1));
            checkOutput("t1_acc_en", int'(FSM_Acc_en), int'(rel >= 4 && rel <= 7));
            checkOutput("t1_zapis", int'(FSM_Acc_zapis), int'(rel == 8));
            checkOutput("t1_done", int'(done), int'(rel == 9));
            checkOutput("t1_busy", int'(busy), int'(rel <= 9));
            if (rel >= 2 && rel <= 5) checkOutput("t1_wsp", int'(FSM_adres_wsp), rel - 2);
            step();
        end
        direct_mode = 1'b0;

        // Three back-to-back frames of 3 taps from a fresh write pointer
        $display("[TB] back-to-back frames");
        applyReset();
        for (int f = 0; f < 3; f++) begin
            applyStimulus(6'd3, 8'($urandom_range(0, 255)));
            waitIdle();
        end

        // Zero taps, then an oversized tap count
        $display("[TB] zero and clamped tap counts");
        applyStimulus(6'd0, 8'($urandom_range(0, 255)));
        for (int rel = 1; rel <= 5; rel++) begin
            checkOutput("t3_acc_en", int'(FSM_Acc_en), 0);
            checkOutput("t3_zapis", int'(FSM_Acc_zapis), int'(rel == 4));
            checkOutput("t3_done", int'(done), int'(rel == 5));
            step();
        end
        waitIdle();
        applyStimulus(6'd40, 8'($urandom_range(0, 255)));
        waitIdle();

        // Starts during MAC and during DONE are overruns only
        $display("[TB] overrun starts");
        applyStimulus(6'd6, 8'($urandom_range(0, 255)));
        step();
        applyStimulus(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
        n = 0;
        while (cyc < busy_until && n < 100) begin
            step();
            n++;
        end
        applyStimulus(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
        waitIdle();
        step();
        step();
        checkOutput("t4_no_second_frame", int'(busy), 0);

        // Reset in the second MAC cycle
        $display("[TB] reset mid-frame");
        applyStimulus(6'd5, 8'($urandom_range(0, 255)));
        step();
        step();
        applyReset();
        checkOutput("t5_busy", int'(busy), 0);
        checkOutput("t5_we", int'(FSM_probka_we), 0);
        checkOutput("t5_probki", int'(FSM_adres_probki), 0);
        checkOutput("t5_wsp", int'(FSM_adres_wsp), 0);
        checkOutput("t5_reset_acc", int'(FSM_reset_Acc), 0);
        checkOutput("t5_done", int'(done), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("t5_quiet_acc_en", int'(FSM_Acc_en), 0);
            checkOutput("t5_quiet_zapis", int'(FSM_Acc_zapis), 0);
        end
        applyStimulus(6'd2, 8'($urandom_range(0, 255)));
        checkOutput("t5_restart_we", int'(FSM_probka_we), 1);
        checkOutput("t5_restart_addr", int'(FSM_adres_probki), 0);
        waitIdle();

        // Randomised frames with occasional overrun starts
        $display("[TB] random frames");
        for (int f = 0; f < 40; f++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       t = 6'd0;
                1:       t = 6'd1;
                2:       t = 6'd32;
                3:       t = 6'($urandom_range(33, 63));
                default: t = 6'($urandom_range(2, 31));
            endcase
            applyStimulus(t, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin
                n = int'($urandom_range(0, busy_until - cyc));
                repeat (n) step();
                applyStimulus(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
            end
            waitIdle();
            n = int'($urandom_range(0, 3));
            repeat (n) step();
        end

        repeat (4) step();
        checkOutput("pending_clear", q_clear.size(), 0);
        checkOutput("pending_tap", q_tap.size(), 0);
        checkOutput("pending_done", q_done.size(), 0);
        checkOutput("pending_overrun", q_ovr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
